// File: rtl/ifetch_ctrl_pkg.sv
// rtl/ifetch_ctrl_pkg.sv - shared scpu fetch definitions: widths, reset PC, FIFO entry layout
package ifetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Wraps modulo 2^32 by construction.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of {pc, inst} entries; flush wins over push
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_push, do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == DEPTH_C);
    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
            if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; count gates validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && !do_pop && full));

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - scpu fetch sequencer: PC, 1-cycle imem issue, fetch FIFO, redirect squash; IFETCH_MISALIGN_CHK_EN adds misalign_err
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic            misalign_err
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            fire, issue, push, park;
    logic [XLEN-1:0] redir_target;
    fetch_entry_t    wr_entry, rd_entry;

    assign redir_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef IFETCH_MISALIGN_CHK_EN
    logic park_q, park_d;

    // A misaligned redirect parks fetch until an aligned redirect arrives.
    assign park_d       = redirect_valid ? (redirect_pc[1:0] != 2'b00) : park_q;
    assign park         = park_q;
    assign misalign_err = park_q;

    always_ff @(posedge clk) begin
        if (rst) park_q <= 1'b0;
        else     park_q <= park_d;
    end
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign park                = 1'b0;
`endif

    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign fire      = out_valid & out_ready;

    always_comb begin
        issue = 1'b0;
        if (!rst && !redirect_valid && !park) begin
            issue = (occupancy < DEPTH_OCC) || ((occupancy == DEPTH_OCC) && fire);
        end
    end

    // Redirect clears inflight, so the wrong-path response next cycle is never pushed.
    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = 1'b0;
        if (redirect_valid) begin
            pc_d = redir_target;
        end else if (issue) begin
            pc_d       = next_pc(pc_q);
            rsp_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign push     = inflight_q & ~redirect_valid;
    assign wr_entry = '{pc: rsp_pc_q, inst: imem_rdata};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (fire),
        .flush_i (redirect_valid),
        .rdata_o (rd_entry),
        .count_o (fifo_count)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_valid = (fifo_count != '0);
    assign out_pc    = out_valid ? rd_entry.pc : '0;
    assign out_inst  = out_valid ? rd_entry.inst : '0;

endmodule
